// File: rtl/mod_exp.sv
// mod_exp: bit-serial modular exponentiator, result = base^exp mod modulus.
// Left-to-right square-and-multiply over an interleaved shift-add modular
// multiplier; one conditional-subtract reduction per operand bit per cycle.
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - asynchronous reset, active low
//   start    - request, accepted only while busy=0
//   base     - message / ciphertext (any value, reduced internally)
//   exp      - exponent (e or d)
//   modulus  - n
//   busy     - high from the accepting edge until done is issued
//   done     - one-cycle pulse, result/err valid from this cycle
//   result   - last result, held until replaced by the next run
//   err      - set with done when modulus was 0, cleared on accept
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; operands captured on accept
// S_REDUCE | b = base mod n, one base bit per cycle (MSB first)
// S_SQR    | acc = acc*acc mod n, one acc bit per cycle
// S_MUL    | acc = acc*b mod n, taken after SQR when exp[i]=1
// S_DONE   | publish result/err; done and busy update on the leaving edge

module mod_exp #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  K_MAX   = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  K_ONE   = CW'(1);
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_SQR,
    S_MUL,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] n_q, n_d;
  // b, acc and p carry one spare bit so the doubled value fits before the
  // conditional subtract; after every step they are back below n.
  logic [WIDTH:0]   b_q, b_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [CW-1:0]    k_q, k_d;
  logic [CW-1:0]    i_q, i_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]   n_ext;
  logic [WIDTH:0]   r_sh, r_red;
  logic [WIDTH:0]   p_sh, p_dbl, y_op, p_sum, p_red;
  logic [WIDTH-1:0] acc_lo;

  assign n_ext = {1'b0, n_q};

  // Reduction of base: shift in one base bit, subtract n at most once.
  assign r_sh  = (b_q << 1) | {{WIDTH{1'b0}}, base_q[k_q]};
  assign r_red = (r_sh >= n_ext) ? (r_sh - n_ext) : r_sh;

  // Multiply step: p = 2p mod n, then conditionally add y mod n.
  // x is always acc; y is acc when squaring, b when multiplying.
  assign acc_lo = acc_q[WIDTH-1:0];
  assign y_op   = (state_q == S_MUL) ? b_q : acc_q;
  assign p_sh   = p_q << 1;
  assign p_dbl  = (p_sh >= n_ext) ? (p_sh - n_ext) : p_sh;
  assign p_sum  = p_dbl + (acc_lo[k_q] ? y_op : '0);
  assign p_red  = (p_sum >= n_ext) ? (p_sum - n_ext) : p_sum;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    exp_d    = exp_q;
    n_d      = n_q;
    b_d      = b_q;
    acc_d    = acc_q;
    p_d      = p_q;
    k_d      = k_q;
    i_d      = i_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = base;
          exp_d  = exp;
          n_d    = modulus;
          busy_d = 1'b1;
          err_d  = 1'b0;
          b_d    = '0;
          p_d    = '0;
          k_d    = K_MAX;
          i_d    = K_MAX;
          if (modulus <= WIDTH'(1)) begin
            acc_d   = '0;
            state_d = S_DONE;
          end else begin
            acc_d   = ONE_EXT;
            state_d = S_REDUCE;
          end
        end
      end

      S_REDUCE: begin
        b_d = r_red;
        if (k_q == '0) begin
          k_d     = K_MAX;
          p_d     = '0;
          state_d = S_SQR;
        end else begin
          k_d = k_q - K_ONE;
        end
      end

      S_SQR, S_MUL: begin
        p_d = p_red;
        if (k_q == '0) begin
          acc_d = p_red;
          p_d   = '0;
          k_d   = K_MAX;
          if ((state_q == S_SQR) && exp_q[i_q]) begin
            state_d = S_MUL;
          end else if (i_q == '0) begin
            state_d = S_DONE;
          end else begin
            i_d     = i_q - K_ONE;
            state_d = S_SQR;
          end
        end else begin
          k_d = k_q - K_ONE;
        end
      end

      S_DONE: begin
        // acc already holds 0 for the degenerate moduli.
        result_d = acc_q[WIDTH-1:0];
        err_d    = (n_q == '0);
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      k_q      <= '0;
      i_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      n_q      <= n_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      k_q      <= k_d;
      i_q      <= i_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: doc/mod_exp.md
# mod_exp

- Bit-serial modular exponentiator: computes `result = base^exp mod modulus` using left-to-right square-and-multiply over interleaved shift-add modular multiplication.
- Sits directly downstream of the private-exponent calculator. It consumes `d` (or public `e`) as `exp` and performs RSA encryption/decryption on a message block.
- No wide multipliers or dividers; one modular-reduction step per cycle.

## Interface

Parameters:
- `WIDTH`, default 128: operand width for base, exp, modulus and result.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset (asserted when 0).
- `start`, input, 1: request; accepted only while `busy`=0.
- `base`, input, WIDTH: message/ciphertext. Any value; reduced internally.
- `exp`, input, WIDTH: exponent (e or d).
- `modulus`, input, WIDTH: n.
- `busy`, output, 1: high from the accepting edge until `done` is issued.
- `done`, output, 1: one-cycle pulse; `result`/`err` are valid from this cycle.
- `result`, output, WIDTH: holds its last value until the next accepted start.
- `err`, output, 1: set with `done` when `modulus`==0. Cleared on the next accept.

## Operation

- States are IDLE, REDUCE, SQR, MUL, DONE.
- **Reset:** while `rst`=0, state goes to IDLE and `busy`=0, `done`=0, `err`=0, `result`=0. Reset mid-operation aborts the operation with no result.
- **Accept (IDLE, `start`=1):**
  - Capture `base`, `exp` and `modulus` into internal registers; later input changes are ignored.
  - Set `busy`=1 and clear `err`.
  - `start` while `busy`=1 is ignored.
- **Degenerate modulus:** if `modulus`==0, go to DONE with `result`=0 and `err`=1. If `modulus`==1, go to DONE with `result`=0 and `err`=0.
- **Otherwise**, initialise and go to REDUCE:
  - `r`=0, `acc`=1.
  - Exponent bit index `i`=WIDTH-1.
  - Step counter `k`=WIDTH-1.
- **REDUCE:** WIDTH cycles. Each cycle: `r = 2r + base[k]`; if `r` >= n then `r = r - n`. Width is WIDTH+1 bits.
  - After bit 0, `b = r`, which satisfies `b` < n.
  - Go to SQR.
- **Modular multiply step** (shared by SQR and MUL), computing `acc*y` mod n over WIDTH cycles:
  - `p = 2p`; if `p` >= n then `p = p - n`.
  - If `x[k]` is set, `p = p + y`; if `p` >= n then `p = p - n`.
  - `p` is WIDTH+1 bits wide and is cleared at entry.
  - The invariant `p` < n holds after every step.
- **SQR:** multiply with `x`=`acc`, `y`=`acc`. When done, `acc = p`.
  - If `exp[i]`=1, go to MUL.
  - Else if `i`=0, go to DONE.
  - Else decrement `i` and go to SQR.
- **MUL:** multiply with `x`=`acc`, `y`=`b`. When done, `acc = p`.
  - If `i`=0, go to DONE; else decrement `i` and go to SQR.
- **DONE:** for one cycle, `result = acc` (or the degenerate value), `done`=1, `busy`=0. Then go to IDLE.
- **Iteration count:** all WIDTH exponent bits are processed, leading zeros included (squaring 1 is harmless). `exp`=0 therefore yields 1.
- **Arithmetic:** all arithmetic is unsigned. No intermediate exceeds 2n-1 < 2^(WIDTH+1).

## Timing

- **Latency:** `done` is high N cycles after the accepting edge.
  - N = 1 + WIDTH + WIDTH·WIDTH + WIDTH·popcount(`exp`).
  - The count is data-dependent only through popcount.
  - N = 1 for `modulus` <= 1.
- **Back-to-back:** `start` may be reasserted in the cycle `done` is high. It is accepted on the next edge, once the state is IDLE.
- **Outputs:** `busy` and `done` are registered and never high simultaneously.
- **Reset:** deasserting reset does not start an operation; a fresh `start` is required.

## Test plan

All scenarios use `WIDTH`=16.
- **Basic:** base=4, exp=13, modulus=497 -> `result`=445, `err`=0. `done` exactly 321 cycles after accept; `busy` high throughout.
- **Unreduced base:** base=500, exp=13, modulus=497 -> `result`=444 (same as 3^13 mod 497).
- **RSA round trip** (n=3233, e=17, d=2753):
  - Encrypt m=65 -> 2790.
  - Feed 2790 back with d=2753, issuing `start` in the `done` cycle -> 65.
- **Edge cases:**
  - exp=0, modulus=97, base=5 -> `result`=1.
  - modulus=1 -> `result`=0, `err`=0, `done` 1 cycle after accept.
  - modulus=0 -> `result`=0, `err`=1.
- **Start while busy:** assert `start` with different operands mid-run -> ignored, first result unaffected.
- **Reset mid-run:** drive `rst`=0 midway through a run.
  - Immediately `busy`=0, `done`=0, `result`=0, `err`=0.
  - No `done` pulse ever appears for the aborted run.
  - A new run afterwards produces the correct result.
